// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: definitions shared by the RAM writer and the ROM/RAM reader.
//   CNT_MAX_DEF    - default debounce hold count (20 ms at 50 MHz)
//   ST_IDLE/FILL/DONE - fill FSM state codes
//   pat_e          - test pattern select (incrementing / inverted address)
package ram_ctrl_pkg;

  localparam logic [23:0] CNT_MAX_DEF = 24'd999_999;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic {
    PAT_INC = 1'b0,
    PAT_INV = 1'b1
  } pat_e;

endpackage

// File: rtl/key_filter.sv
// key_filter: debounces one active-low push-button.
//   sys_clk    - system clock, rising edge
//   sys_rst    - synchronous active-high reset, clears the hold counter
//   key_in     - raw active-low key
//   press_flag - single-cycle pulse once the key has been low CNT_MAX cycles
module key_filter
  import ram_ctrl_pkg::*;
#(
  parameter logic [23:0] CNT_MAX = CNT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic press_flag
);

  logic [23:0] cnt_q, cnt_d;

  // Saturating at CNT_MAX keeps a held key from ever re-reaching the
  // flag value, so one press gives exactly one flag.
  always_comb begin
    cnt_d = cnt_q;
    if (key_in) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gating with the live key means the key must still be low on its
  // CNT_MAX-th consecutive cycle; shorter glitches never flag.
  assign press_flag = !key_in && (cnt_q == CNT_MAX - 24'd1);

endmodule

// File: rtl/ram_wr_ctrl.sv
// ram_wr_ctrl: fills a single-port RAM with a key-selected test pattern.
//   sys_clk  - system clock, rising edge
//   sys_rst  - synchronous active-high reset (aborts any burst)
//   key1     - active-low key, starts an incrementing-pattern burst
//   key2     - active-low key, starts an inverted-pattern burst
//   wr_en    - RAM write enable, one word per cycle
//   wr_addr  - RAM write address (0 while idle)
//   wr_data  - RAM write data (0 while idle)
//   busy     - high during the fill burst
//   done     - one-cycle pulse after the last word
module ram_wr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter logic [23:0] CNT_MAX = CNT_MAX_DEF,
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              key1,
  input  logic              key2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  logic flag1, flag2;

  key_filter #(.CNT_MAX(CNT_MAX)) u_key1 (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_in    (key1),
    .press_flag(flag1)
  );

  key_filter #(.CNT_MAX(CNT_MAX)) u_key2 (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_in    (key2),
    .press_flag(flag2)
  );

  function automatic logic [DATA_W-1:0] fill_word(input logic [ADDR_W-1:0] a,
                                                  input pat_e p);
    logic [DATA_W-1:0] w;
    w = DATA_W'(a);
    if (p == PAT_INV) begin
      w = ~w;
    end
    return w;
  endfunction

  logic [1:0]        state_q, state_d;
  pat_e              pat_q, pat_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state and next-output decode; outputs default to their idle
  // value (all zero) so address/data read 0 whenever wr_en is low.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // key1 takes priority when both flags land together
        if (flag1 || flag2) begin
          state_d   = ST_FILL;
          pat_d     = flag1 ? PAT_INC : PAT_INV;
          wr_en_d   = 1'b1;
          busy_d    = 1'b1;
          wr_data_d = fill_word('0, flag1 ? PAT_INC : PAT_INV);
        end
      end
      ST_FILL: begin
        // Exit on the all-ones address; key flags are ignored here.
        if (wr_addr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          busy_d    = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          wr_data_d = fill_word(wr_addr_q + 1'b1, pat_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= PAT_INC;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/ram_wr_ctrl.md
# ram_wr_ctrl

Writer-side counterpart to the ROM address sequencer: fills an external single-port RAM (2**ADDR_W words × DATA_W bits) with a test pattern chosen by two push-buttons. Each key is debounced on-chip. A valid press starts one full-depth burst of writes, one word per clock. The block sits between the board keys and the RAM IP's write port; a separate reader later scans the same RAM.

## Interface
- CNT_MAX, 24'd999_999, debounce hold count in sys_clk cycles (20 ms at 50 MHz; benches use 24'd99)
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W
- DATA_W, 8, RAM data width (must equal ADDR_W)
- sys_clk  input  1  system clock; all logic on rising edge
- sys_rst  input  1  synchronous, active-high reset
- key1  input  1  active-low push-button; a press selects the incrementing pattern
- key2  input  1  active-low push-button; a press selects the inverted pattern
- wr_en  output  1  RAM write enable, one word per cycle while high
- wr_addr  output  ADDR_W  RAM write address
- wr_data  output  DATA_W  RAM write data
- busy  output  1  high while a fill burst is in progress
- done  output  1  one-cycle pulse after the last word of a burst

## Operation
- Debounce, one instance per key:
  - Counter cnt (24 bit) clears whenever key = 1.
  - While key = 0, cnt increments and saturates at CNT_MAX.
  - press_flag pulses for exactly one cycle, on the cycle cnt == CNT_MAX-1.
  - One flag per press; holding the key gives no repeat. Glitches shorter than CNT_MAX cycles give no flag.
- FSM states: IDLE, FILL, DONE.
  - IDLE: on flag1 go to FILL with pattern INC. Otherwise, on flag2 go to FILL with pattern INV. If flag1 and flag2 arrive in the same cycle, flag1 wins.
  - FILL: wr_en = 1. wr_addr increments by 1 each cycle from 0. wr_data = wr_addr for INC, ~wr_addr for INV. After the word at address 2**ADDR_W-1, go to DONE.
  - DONE: lasts one cycle, with done = 1. Then return to IDLE.
- Key flags that arrive in FILL or DONE are discarded, not queued. A burst is never restarted or truncated by keys.
- Pattern select is latched at the FILL entry and held for the whole burst.
- The address counter is ADDR_W bits wide, with natural wrap. The FILL exit is decoded on the all-ones address, not on overflow.
- Reset, whether idle or mid-burst, returns the FSM to IDLE and both debounce counters to 0. The RAM contents are left partially written; this is acceptable.

## Timing
- Reset values: wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, done = 0. All outputs are registered.
- A key held low from cycle 0 produces its flag in cycle CNT_MAX-1.
- Burst timeline, with flag in cycle k:
  - Cycle k+1: first write (wr_en = 1, addr 0, busy = 1).
  - Cycle k+2**ADDR_W: last write (addr all-ones).
  - Cycle k+2**ADDR_W+1: wr_en = 0, busy = 0, done = 1.
- The next burst can start at the earliest from a flag in cycle k+2**ADDR_W+2.
- Throughput: 2**ADDR_W words in 2**ADDR_W consecutive cycles, with no gaps.
- wr_addr and wr_data are only meaningful while wr_en = 1. While wr_en = 0 they hold 0.

## Structure
- Shared package ram_ctrl_pkg holds:
  - the state enumeration (IDLE, FILL, DONE);
  - the pattern enumeration (INC, INV);
  - the default CNT_MAX constant, shared with the ROM reader.
- Sub-module key_filter (parameter CNT_MAX; ports sys_clk, sys_rst, key_in, press_flag) is instantiated twice. The same module serves the reader.
- Top-level contents: the FSM, the address counter, the pattern mux, and the output registers.

## Test plan
All scenarios use CNT_MAX = 99.
- Reset held 3 cycles, then released with keys high -> all outputs 0, no wr_en for 1000 cycles.
- key1 low for 20 cycles, then high -> no flag, no write.
- key1 low for 200 cycles -> 256 consecutive writes starting 1 cycle after the flag: addr 0..255, data 0x00..0xFF. Then done high for 1 cycle. A single burst only, even though the key is still held.
- key2 pressed -> 256 writes with data = ~addr (0xFF at addr 0, 0x00 at addr 255); busy high for exactly 256 cycles.
- key1 and key2 released low on the same cycle -> INC pattern; the key2 flag is discarded. A key2 press during the burst -> no restart, no second burst.
- sys_rst asserted at addr 100 of a burst -> next cycle wr_en = 0, busy = 0, addr = 0, no done. A new key1 press afterwards starts a fresh burst at addr 0.
